// File: rtl/exec_alu_mdiv_pkg.sv
// Shared types for the Risc-Inci integer execute unit: op codes, FSM states, decode helpers.
package exec_alu_mdiv_pkg;

  localparam int cOpW    = 5;
  localparam int cMulLat = 2;

  typedef enum logic [cOpW-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_PASS   = 5'd10,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } tAluOp;

  typedef enum logic [1:0] {IDLE, MUL, DIV} tExecState;

  function automatic logic isMdivOp(input logic [cOpW-1:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic isMulOp(input logic [cOpW-1:0] op);
    return op[4:2] == 3'b100;
  endfunction

  function automatic logic isDivOp(input logic [cOpW-1:0] op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/exec_alu_mdiv_if.sv
// Issue/result bus of the execute unit; master = decode/writeback side, slave = exec_alu_mdiv.
interface exec_alu_mdiv_if
  import exec_alu_mdiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_SEL_W = 5
);
  logic                 iValid;
  logic                 oReady;
  logic [cOpW-1:0]      iOp;
  logic [XLEN-1:0]      iOperand1;
  logic [XLEN-1:0]      iOperand2;
  logic [REG_SEL_W-1:0] iRdAddr;
  logic                 iFlush;
  logic                 oValid;
  logic [XLEN-1:0]      oData;
  logic [REG_SEL_W-1:0] oRdAddr;
  logic                 oIllegal;
  logic                 oBusy;

  modport master (
    output iValid, iOp, iOperand1, iOperand2, iRdAddr, iFlush,
    input  oReady, oValid, oData, oRdAddr, oIllegal, oBusy
  );

  modport slave (
    input  iValid, iOp, iOperand1, iOperand2, iRdAddr, iFlush,
    output oReady, oValid, oData, oRdAddr, oIllegal, oBusy
  );
endinterface

// File: rtl/exec_alu_mdiv_divider.sv
// alu_divider: restoring radix-2 divider, one quotient bit per cycle on operand magnitudes.
// done is asserted exactly XLEN+1 cycles after start; result is sign-corrected combinationally.
module alu_divider
  import exec_alu_mdiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            signedMode,
  input  logic            remSel,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;

  logic            busy_q, qneg_q, rneg_q, rsel_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN-1:0] rem_d, quo_d;
  logic [XLEN:0]   shl, trial;
  logic            a_neg, b_neg;

  assign a_neg = signedMode & dividend[XLEN-1];
  assign b_neg = signedMode & divisor[XLEN-1];

  // A divisor of zero never borrows, so the quotient fills with ones and the
  // remainder ends as |dividend|; only the quotient sign flip must be suppressed.
  always_comb begin
    shl   = {rem_q, quo_q[XLEN-1]};
    trial = shl - {1'b0, dvs_q};
    rem_d = trial[XLEN] ? shl[XLEN-1:0] : trial[XLEN-1:0];
    quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      rsel_q <= 1'b0;
    end else if (flush) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(XLEN);
      rem_q  <= '0;
      quo_q  <= a_neg ? -dividend : dividend;
      dvs_q  <= b_neg ? -divisor : divisor;
      qneg_q <= (a_neg ^ b_neg) & (|divisor);
      rneg_q <= a_neg;
      rsel_q <= remSel;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - CW'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done   = busy_q & (cnt_q == '0);
  assign result = rsel_q ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);

endmodule

// File: rtl/exec_alu_mdiv.sv
// Integer execute unit: 2-cycle RV32I ALU pipe plus optional RV32M multiply/divide.
// Build with RISCINCI_MDIV_EN defined to include the M-extension datapath and FSM.
module exec_alu_mdiv
  import exec_alu_mdiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_SEL_W = 5,
  parameter int MUL_LAT   = cMulLat
) (
  input logic           iClk,
  input logic           iRstN,
  exec_alu_mdiv_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  logic                 issue, ready;
  logic                 s1_vld_q;
  logic [cOpW-1:0]      s1_op_q;
  logic [XLEN-1:0]      s1_a_q, s1_b_q;
  logic [REG_SEL_W-1:0] s1_rd_q;
  logic                 o_vld_q, o_ill_q;
  logic [XLEN-1:0]      o_data_q;
  logic [REG_SEL_W-1:0] o_rd_q;
  logic [XLEN-1:0]      alu_res, res;
  logic                 alu_ill, base_vld, res_vld, res_ill;
  logic [SHW-1:0]       shamt;

  assign issue = bus.iValid & ready & ~bus.iFlush;
  assign shamt = s1_b_q[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (s1_op_q)
      OP_ADD:  alu_res = s1_a_q + s1_b_q;
      OP_SUB:  alu_res = s1_a_q - s1_b_q;
      OP_SLL:  alu_res = s1_a_q << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(s1_a_q) < $signed(s1_b_q)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, s1_a_q < s1_b_q};
      OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
      OP_SRL:  alu_res = s1_a_q >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(s1_a_q) >>> shamt);
      OP_OR:   alu_res = s1_a_q | s1_b_q;
      OP_AND:  alu_res = s1_a_q & s1_b_q;
      OP_PASS: alu_res = s1_a_q;
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef RISCINCI_MDIV_EN
  tExecState         state_q;
  logic              out_mdiv_q;
  logic              mul_in_vld, mul_out_vld, div_done;
  logic [XLEN-1:0]   mul_res, mul_out, div_res;
  logic [2*XLEN-1:0] ma, mb, mprod;

  assign ready      = (state_q == IDLE);
  assign base_vld   = s1_vld_q & ~isMdivOp(s1_op_q);
  assign mul_in_vld = s1_vld_q & isMulOp(s1_op_q);

  // Operand A is signed for all but MULHU, B only for MULH; the low half is sign-agnostic.
  assign ma      = {{XLEN{(s1_op_q != OP_MULHU) & s1_a_q[XLEN-1]}}, s1_a_q};
  assign mb      = {{XLEN{(s1_op_q == OP_MULH) & s1_b_q[XLEN-1]}}, s1_b_q};
  assign mprod   = ma * mb;
  assign mul_res = (s1_op_q == OP_MUL) ? mprod[XLEN-1:0] : mprod[2*XLEN-1:XLEN];

  if (MUL_LAT > 1) begin : g_mul_pipe
    logic [MUL_LAT-2:0]           vld_pipe_q;
    logic [MUL_LAT-2:0][XLEN-1:0] res_pipe_q;

    always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN)          vld_pipe_q <= '0;
      else if (bus.iFlush) vld_pipe_q <= '0;
      else begin
        vld_pipe_q[0] <= mul_in_vld;
        for (int i = 1; i < MUL_LAT-1; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end

    always_ff @(posedge iClk) begin
      res_pipe_q[0] <= mul_res;
      for (int i = 1; i < MUL_LAT-1; i++) res_pipe_q[i] <= res_pipe_q[i-1];
    end

    assign mul_out_vld = vld_pipe_q[MUL_LAT-2];
    assign mul_out     = res_pipe_q[MUL_LAT-2];
  end else begin : g_mul_comb
    assign mul_out_vld = mul_in_vld;
    assign mul_out     = mul_res;
  end

  // Divider starts straight from the issue so the result lands at issue+XLEN+2.
  alu_divider #(.XLEN(XLEN)) u_div (
    .clk        (iClk),
    .rst_n      (iRstN),
    .start      (issue & isDivOp(bus.iOp)),
    .signedMode (~bus.iOp[0]),
    .remSel     (bus.iOp[1]),
    .dividend   (bus.iOperand1),
    .divisor    (bus.iOperand2),
    .flush      (bus.iFlush),
    .done       (div_done),
    .result     (div_res)
  );

  assign res_vld  = base_vld | mul_out_vld | div_done;
  assign res      = base_vld ? alu_res : (mul_out_vld ? mul_out : div_res);
  assign res_ill  = base_vld & alu_ill;
  assign bus.oBusy = s1_vld_q | (state_q != IDLE);

  // out_mdiv_q marks the cycle an M result is on the outputs; the FSM leaves then.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q    <= IDLE;
      out_mdiv_q <= 1'b0;
    end else if (bus.iFlush) begin
      state_q    <= IDLE;
      out_mdiv_q <= 1'b0;
    end else begin
      out_mdiv_q <= mul_out_vld | div_done;
      case (state_q)
        IDLE: begin
          if (issue && isMulOp(bus.iOp))      state_q <= MUL;
          else if (issue && isDivOp(bus.iOp)) state_q <= DIV;
        end
        MUL, DIV: if (out_mdiv_q) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end
`else
  assign ready     = 1'b1;
  assign base_vld  = s1_vld_q;
  assign res_vld   = base_vld;
  assign res       = alu_res;
  assign res_ill   = alu_ill;
  assign bus.oBusy = s1_vld_q;
`endif

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      s1_vld_q <= 1'b0;
      s1_op_q  <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_rd_q  <= '0;
      o_vld_q  <= 1'b0;
      o_ill_q  <= 1'b0;
      o_data_q <= '0;
      o_rd_q   <= '0;
    end else if (bus.iFlush) begin
      s1_vld_q <= 1'b0;
      o_vld_q  <= 1'b0;
    end else begin
      s1_vld_q <= issue;
      if (issue) begin
        s1_op_q <= bus.iOp;
        s1_a_q  <= bus.iOperand1;
        s1_b_q  <= bus.iOperand2;
        s1_rd_q <= bus.iRdAddr;
      end
      o_vld_q <= res_vld;
      if (res_vld) begin
        o_ill_q  <= res_ill;
        o_rd_q   <= s1_rd_q;
        o_data_q <= (res_ill || s1_rd_q == '0) ? '0 : res;
      end
    end
  end

  assign bus.oReady   = ready;
  assign bus.oValid   = o_vld_q;
  assign bus.oData    = o_data_q;
  assign bus.oRdAddr  = o_rd_q;
  assign bus.oIllegal = o_ill_q;

endmodule

// File: tb/tb_exec_alu_mdiv.sv
// Directed bench for exec_alu_mdiv (XLEN=32, MUL_LAT=2); M-extension vectors only when RISCINCI_MDIV_EN is set.
module tb_exec_alu_mdiv;
  import exec_alu_mdiv_pkg::*;

  logic iClk  = 1'b0;
  logic iRstN = 1'b0;
  always #5 iClk = ~iClk;

  exec_alu_mdiv_if #(.XLEN(32), .REG_SEL_W(5)) bus ();

  exec_alu_mdiv #(.XLEN(32), .REG_SEL_W(5), .MUL_LAT(2)) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.iValid    = 1'b1;
    bus.iOp       = op;
    bus.iOperand1 = a;
    bus.iOperand2 = b;
    bus.iRdAddr   = rd;
  endtask

  // Issue one op and wait (bounded) for its result; lat = -1 on timeout.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int nlo);
    drive(op, a, b, rd);
    tick();
    bus.iValid = 1'b0;
    lat = -1;
    nlo = 0;
    for (int c = 1; c <= 60; c++) begin
      if (!bus.oReady) nlo++;
      if (bus.oValid) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic expect_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                           input int exp_lat, input int exp_nlo, input logic exp_ill);
    int lat, nlo;
    run_op(op, a, b, rd, lat, nlo);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " ready-low cycles"}, 32'(nlo), 32'(exp_nlo));
    chk({tag, " data"}, bus.oData, exp);
    chk({tag, " rd"}, 32'(bus.oRdAddr), 32'(rd));
    chkb({tag, " illegal"}, bus.oIllegal, exp_ill);
    tick();
  endtask

  initial begin
    int seen;
    bus.iValid = 1'b0; bus.iFlush = 1'b0; bus.iOp = '0;
    bus.iOperand1 = '0; bus.iOperand2 = '0; bus.iRdAddr = '0;

    // reset state
    #12;
    chkb("rst oValid", bus.oValid, 1'b0);
    chkb("rst oReady", bus.oReady, 1'b1);
    chkb("rst oBusy", bus.oBusy, 1'b0);
    chkb("rst oIllegal", bus.oIllegal, 1'b0);
    chk("rst oData", bus.oData, 32'h0);
    chk("rst oRdAddr", 32'(bus.oRdAddr), 32'h0);
    iRstN = 1'b1;
    tick(); tick();

    // back-to-back ADD then SRA, one result per cycle
    drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd5);
    tick();
    chkb("b2b ready", bus.oReady, 1'b1);
    chkb("b2b busy", bus.oBusy, 1'b1);
    drive(OP_SRA, 32'h8000_0000, 32'd4, 5'd6);
    tick();
    bus.iValid = 1'b0;
    chkb("add valid", bus.oValid, 1'b1);
    chk("add data", bus.oData, 32'h8000_0000);
    chk("add rd", 32'(bus.oRdAddr), 32'd5);
    tick();
    chkb("sra valid", bus.oValid, 1'b1);
    chk("sra data", bus.oData, 32'hF800_0000);
    chk("sra rd", 32'(bus.oRdAddr), 32'd6);
    tick();
    chkb("b2b drained", bus.oValid, 1'b0);
    chkb("b2b idle", bus.oBusy, 1'b0);

    // base ops
    expect_op("sub",  OP_SUB,  32'd5,          32'd7,          5'd1, 32'hFFFF_FFFE, 2, 0, 1'b0);
    expect_op("sll",  OP_SLL,  32'h1,          32'h23,         5'd2, 32'h8,         2, 0, 1'b0);
    expect_op("slt",  OP_SLT,  32'h8000_0000,  32'h0,          5'd3, 32'h1,         2, 0, 1'b0);
    expect_op("sltu", OP_SLTU, 32'h8000_0000,  32'h0,          5'd4, 32'h0,         2, 0, 1'b0);
    expect_op("xor",  OP_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  5'd5, 32'h0FF0_0FF0, 2, 0, 1'b0);
    expect_op("srl",  OP_SRL,  32'h8000_0000,  32'd31,         5'd6, 32'h1,         2, 0, 1'b0);
    expect_op("or",   OP_OR,   32'h1234_0000,  32'h0000_5678,  5'd7, 32'h1234_5678, 2, 0, 1'b0);
    expect_op("and",  OP_AND,  32'hFFFF_0000,  32'h0F0F_0F0F,  5'd8, 32'h0F0F_0000, 2, 0, 1'b0);
    expect_op("pass", OP_PASS, 32'hDEAD_BEEF,  32'h1111_1111,  5'd9, 32'hDEAD_BEEF, 2, 0, 1'b0);
    expect_op("op31", 5'd31,   32'h5,          32'h6,          5'd9, 32'h0,         2, 0, 1'b1);
    expect_op("op11", 5'd11,   32'h5,          32'h6,          5'd3, 32'h0,         2, 0, 1'b1);
    expect_op("x0",   OP_ADD,  32'd1,          32'd2,          5'd0, 32'h0,         2, 0, 1'b0);

`ifdef RISCINCI_MDIV_EN
    expect_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, 3, 3, 1'b0);
    expect_op("mul",    OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h0000_0001, 3, 3, 1'b0);
    expect_op("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0,         3, 3, 1'b0);
    expect_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFF, 3, 3, 1'b0);
    expect_op("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd14, 32'hFFFF_FFFD, 34, 34, 1'b0);
    expect_op("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd15, 32'hFFFF_FFFF, 34, 34, 1'b0);
    expect_op("divu0",  OP_DIVU,   32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 34, 34, 1'b0);
    expect_op("rem0",   OP_REM,    32'hFFFF_FFF9, 32'd0,         5'd17, 32'hFFFF_FFF9, 34, 34, 1'b0);
    expect_op("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0,         34, 34, 1'b0);
    expect_op("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 34, 34, 1'b0);
    expect_op("divu",   OP_DIVU,   32'd100,       32'd7,         5'd20, 32'd14,        34, 34, 1'b0);
    expect_op("remu",   OP_REMU,   32'd100,       32'd7,         5'd21, 32'd2,         34, 34, 1'b0);
    expect_op("op24",   5'd24,     32'd1,         32'd1,         5'd22, 32'h0,         2, 0, 1'b1);

    // flush ten cycles into a divide; the ADD offered alongside must be dropped
    drive(OP_DIV, 32'd100, 32'd3, 5'd7);
    tick();
    bus.iValid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chkb("div busy", bus.oBusy, 1'b1);
    chkb("div not ready", bus.oReady, 1'b0);
`else
    expect_op("mul nomdiv", OP_MUL, 32'd3, 32'd4, 5'd10, 32'h0, 2, 0, 1'b1);
    expect_op("div nomdiv", OP_DIV, 32'd8, 32'd2, 5'd11, 32'h0, 2, 0, 1'b1);

    // flush with an ADD in stage 1; the ADD offered alongside must be dropped
    drive(OP_ADD, 32'd1, 32'd1, 5'd3);
    tick();
    chkb("s1 busy", bus.oBusy, 1'b1);
`endif
    drive(OP_ADD, 32'd9, 32'd9, 5'd8);
    bus.iFlush = 1'b1;
    tick();
    bus.iFlush = 1'b0;
    bus.iValid = 1'b0;
    chkb("flush ready", bus.oReady, 1'b1);
    chkb("flush busy", bus.oBusy, 1'b0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.oValid) seen++;
      tick();
    end
    chk("flush no result", 32'(seen), 32'd0);
    expect_op("post flush add", OP_ADD, 32'd3, 32'd4, 5'd4, 32'd7, 2, 0, 1'b0);

    // async reset with work in flight
`ifdef RISCINCI_MDIV_EN
    drive(OP_DIV, 32'd50, 32'd5, 5'd9);
    tick();
    bus.iValid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
`else
    drive(OP_ADD, 32'd50, 32'd5, 5'd9);
    tick();
    bus.iValid = 1'b0;
`endif
    iRstN = 1'b0;
    #1;
    chkb("arst busy", bus.oBusy, 1'b0);
    chkb("arst ready", bus.oReady, 1'b1);
    iRstN = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.oValid) seen++;
      tick();
    end
    chk("arst no result", 32'(seen), 32'd0);
    expect_op("post rst sub", OP_SUB, 32'd10, 32'd3, 5'd2, 32'd7, 2, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/exec_alu_mdiv.md
Name: exec_alu_mdiv

Overview:
Parametrised integer execute unit for the Risc-Inci core. It sits between decode/operand-select and register writeback.
- Base RV32I ops: fully pipelined, fixed 2-cycle latency.
- RV32M multiply: pipelined, parametrised latency.
- RV32M divide/remainder: iterative, one quotient bit per cycle.
- Adds valid/ready issue handshake, flush, illegal-op flagging and x0 write suppression.

Parameters:
XLEN, 32, datapath width (32 or 64)
REG_SEL_W, 5, destination register address width
MUL_LAT, 2, multiplier pipeline stages (1..4)

Ports:
iClk  in  1  clock, rising edge
iRstN  in  1  asynchronous active-low reset
iValid  in  1  issue request
oReady  out  1  unit can accept; issue happens when iValid & oReady
iOp  in  5  operation code, tAluOp
iOperand1  in  XLEN  operand 1 (rs1/pc/imm already selected)
iOperand2  in  XLEN  operand 2 (rs2/imm/const already selected)
iRdAddr  in  REG_SEL_W  destination register
iFlush  in  1  kill all in-flight work
oValid  out  1  one-cycle result strobe
oData  out  XLEN  result
oRdAddr  out  REG_SEL_W  destination of result
oIllegal  out  1  qualifies oValid: op code not supported
oBusy  out  1  any op in flight

Behaviour:
- Reset (iRstN=0, async):
  - oValid, oData, oRdAddr, oIllegal, oBusy all 0.
  - FSM in IDLE; all stage valids 0.
  - oReady = (state==IDLE), so it reads 1 during and after reset.
- Op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS (operand1).
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - All others illegal.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - Shift amount = operand2[$clog2(XLEN)-1:0]; SRA replicates operand1 MSB.
  - SLT/SLTU return zero-extended 1/0.
  - MULH* return upper XLEN bits of the 2*XLEN product with the required signedness.
- Base ops and illegal ops:
  - Cycle 0 issue registers operands/op/rd; cycle 1 computes into the output register.
  - oValid high in cycle 2 after the issue edge.
  - Throughput 1 per cycle; oReady stays 1.
  - Illegal: oIllegal=1, oData=0, same latency.
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL on issue of op 16-19; IDLE→DIV on issue of op 20-23.
  - MUL→IDLE on the cycle the result is presented; DIV→IDLE likewise.
  - oReady=0 in MUL and DIV. Results therefore leave in issue order; a base op issued the cycle before a MUL/DIV completes first.
- MUL: oValid exactly MUL_LAT+1 cycles after issue.
- DIV: oValid exactly XLEN+2 cycles after issue, always, including special cases.
- Divide by zero:
  - DIV/DIVU → all ones.
  - REM/REMU → dividend.
- Signed overflow (DIV -2^(XLEN-1) by -1): quotient = -2^(XLEN-1), remainder 0.
- x0: if oRdAddr==0, oData is forced 0 while oValid still strobes.
- Flush (synchronous):
  - Next edge clears all stage valids and divider state; FSM→IDLE; oValid=0 from the next cycle.
  - An issue in the same cycle as iFlush is dropped.
  - Flush takes priority over a result due that cycle.
- oBusy = any stage valid | state!=IDLE.
- Async reset mid-divide aborts immediately; no result is emitted.

Optional Feature:
RISCINCI_MDIV_EN
- Defined: M-extension datapath and the alu_divider instance are built; FSM has MUL/DIV states.
- Undefined: ops 16-23 are illegal (oIllegal=1, oData=0, 2-cycle latency), oReady is constant 1, and no multiplier/divider logic is synthesised.

Decomposition:
- corePckg gains:
  - tAluOp enum (5-bit, codes above).
  - cMulLat default.
  - tExecState enum {IDLE, MUL, DIV}.
  - Helper function isMdivOp().
- Sub-module alu_divider: restoring radix-2 divider.
  - Ports: start, signedMode, remSel, dividend, divisor, flush, done, result.
  - Handles zero/overflow cases and sign fixup internally.

Test Plan:
- ADD 0x7FFFFFFF+1 issued cycle 10 → oValid cycle 12, oData 0x80000000; back-to-back SRA 0x80000000>>4 in cycle 11 → cycle 13, 0xF8000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF, MUL_LAT=2 → oReady low 3 cycles, oData 0xFFFFFFFE at issue+3; MUL same operands → 0x00000001.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; each oValid at issue+34 for XLEN=32.
- DIVU 5/0 → 0xFFFFFFFF; REM 0x80000000/0xFFFFFFFF → 0; DIV same operands → 0x80000000.
- Flush 10 cycles into a DIV with a base op in stage 1 → no oValid afterwards, oReady=1 and oBusy=0 next cycle, new ADD 3+4 → 7 at +2.
- Op 31 → oIllegal=1, oData 0; ADD with rd=0 → oValid=1, oData 0; build without RISCINCI_MDIV_EN, MUL → oIllegal=1 at +2.
